// File: rtl/regfile_pkg.sv
// Shared types and default widths for the register-file write-back path.
package regfile_pkg;

    localparam int unsigned DW   = 32;
    localparam int unsigned AW   = 5;
    localparam int unsigned NREG = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// N-wide round-robin arbiter: combinational one-hot grant, pointer advances past each winner.
module rr_arbiter #(
    parameter int unsigned N  = 3,
    parameter int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [N-1:0]  req,
    output logic [N-1:0]  gnt_c,
    output logic          gnt_any_c,
    output logic [PW-1:0] gnt_idx_c
);

    logic [PW-1:0] ptr;
    logic [PW-1:0] ptr_nxt;

    // Search from ptr upward, wrapping modulo N; first active request wins.
    always_comb begin
        int unsigned j;
        gnt_c     = '0;
        gnt_any_c = 1'b0;
        gnt_idx_c = '0;
        j         = 0;
        for (int unsigned i = 0; i < N; i++) begin
            j = (32'(ptr) + i) % N;
            if (en && !gnt_any_c && req[j]) begin
                gnt_any_c = 1'b1;
                gnt_idx_c = PW'(j);
                gnt_c     = N'(1) << j;
            end
        end
    end

    always_comb begin
        ptr_nxt = ptr;
        if (gnt_any_c) begin
            ptr_nxt = (32'(gnt_idx_c) == N - 1) ? '0 : gnt_idx_c + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else begin
            ptr <= ptr_nxt;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port owner: zero sweep after start, then round-robin write-back sharing.
// Optional per-requester grant counters under REGFILE_WB_ARBITER_STATS_EN.
module regfile_wb_arbiter #(
    parameter int unsigned NREQ = 3,
    parameter int unsigned DW   = regfile_pkg::DW,
    parameter int unsigned AW   = regfile_pkg::AW,
    parameter int unsigned NREG = regfile_pkg::NREG
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]    req_ready,
    output logic               wrt_en,
    output logic [AW-1:0]      a3,
    output logic [DW-1:0]      wrt,
`ifdef REGFILE_WB_ARBITER_STATS_EN
    output logic [NREQ*16-1:0] grant_cnt,
`endif
    output logic               init_done
);

    import regfile_pkg::*;

    localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_t        state, state_nxt;
    logic [AW-1:0] cnt, cnt_nxt;
    logic          wrt_en_nxt, init_done_nxt;
    logic [AW-1:0] a3_nxt;
    logic [DW-1:0] wrt_nxt;

    logic [NREQ-1:0] gnt_c;
    logic            gnt_any_c;
    logic [PW-1:0]   gnt_idx_c;
    logic [AW-1:0]   gnt_addr_c;
    logic [DW-1:0]   gnt_data_c;

    rr_arbiter #(.N(NREQ), .PW(PW)) u_rr_arbiter (
        .clk       (clk),
        .rst       (rst),
        .en        (state == ST_RUN),
        .req       (req_valid),
        .gnt_c     (gnt_c),
        .gnt_any_c (gnt_any_c),
        .gnt_idx_c (gnt_idx_c)
    );

    assign req_ready  = gnt_c;
    assign gnt_addr_c = req_addr[32'(gnt_idx_c) * AW +: AW];
    assign gnt_data_c = req_data[32'(gnt_idx_c) * DW +: DW];

    // Next state and next write-port values; a3/wrt hold unless a write is issued.
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        wrt_en_nxt = 1'b0;
        a3_nxt     = a3;
        wrt_nxt    = wrt;
        case (state)
            ST_IDLE: begin
                if (start) state_nxt = ST_CLEAR;
            end
            ST_CLEAR: begin
                wrt_en_nxt = 1'b1;
                a3_nxt     = cnt;
                wrt_nxt    = '0;
                if (cnt == AW'(NREG - 1)) begin
                    state_nxt = ST_RUN;
                end else begin
                    cnt_nxt = cnt + AW'(1);
                end
            end
            ST_RUN: begin
                // Writes to x0 are accepted but never reach the register file.
                if (gnt_any_c && gnt_addr_c != '0) begin
                    wrt_en_nxt = 1'b1;
                    a3_nxt     = gnt_addr_c;
                    wrt_nxt    = gnt_data_c;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        init_done_nxt = (state_nxt == ST_RUN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= AW'(1);
            wrt_en    <= 1'b0;
            a3        <= '0;
            wrt       <= '0;
            init_done <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            wrt_en    <= wrt_en_nxt;
            a3        <= a3_nxt;
            wrt       <= wrt_nxt;
            init_done <= init_done_nxt;
        end
    end

`ifdef REGFILE_WB_ARBITER_STATS_EN
    // Saturating handshake counters, one per requester.
    for (genvar i = 0; i < NREQ; i++) begin : g_stats
        logic [15:0] stat_q;
        always_ff @(posedge clk) begin
            if (rst) begin
                stat_q <= '0;
            end else if (req_valid[i] && req_ready[i] && stat_q != 16'hFFFF) begin
                stat_q <= stat_q + 16'd1;
            end
        end
        assign grant_cnt[i*16 +: 16] = stat_q;
    end
`endif

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Owns the single write port (wrt_en, a3, wrt) of the `register` file.
- After reset and `start`, sweeps registers 1..NREG-1 to zero, then enters normal operation.
- In normal operation, shares the write port round-robin among NREQ write-back requesters (ALU, load, CSR) using valid/ready handshakes.
- Sits between the execute/memory stages and `register`; the read ports (a1/a2/rd1/rd2) are untouched.

Parameters:
- NREQ, 3, number of write-back requesters (2..8)
- DW, 32, register data width
- AW, 5, register address width
- NREG, 32, number of registers swept in CLEAR (must be ≤ 2**AW)

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  begin init sweep; sampled only in IDLE
- req_valid  input  NREQ  per-requester write request
- req_addr  input  NREQ*AW  destination addresses; requester i at [i*AW +: AW]
- req_data  input  NREQ*DW  write data; requester i at [i*DW +: DW]
- req_ready  output  NREQ  one-hot grant; the transfer completes when valid&ready are both high
- wrt_en  output  1  register write enable (registered)
- a3  output  AW  register write address (registered)
- wrt  output  DW  register write data (registered)
- init_done  output  1  high in RUN only

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - state=IDLE.
  - rr_ptr=0.
  - sweep counter=1.
  - wrt_en=0, a3=0, wrt=0.
  - req_ready=0, init_done=0.
- FSM states: IDLE, CLEAR, RUN.
- IDLE: all req_ready=0. When start=1 at a clock edge, go to CLEAR.
- CLEAR:
  - Each cycle register wrt_en=1, a3=cnt, wrt=0, then cnt++.
  - After the write of cnt=NREG-1, go to RUN. The sweep takes NREG-1 cycles.
  - req_ready stays 0 throughout.
- RUN:
  - init_done=1. start is ignored.
  - The only exit from RUN is rst.
- Arbitration (RUN only, combinational):
  - Search requesters rr_ptr, rr_ptr+1, … wrapping modulo NREQ.
  - The first with req_valid=1 gets req_ready=1; all other ready bits are 0.
  - If no requester is valid, req_ready=0.
  - On a grant to requester g, rr_ptr ← (g+1) mod NREQ. With no grant, rr_ptr holds.
- Write-back latency:
  - A grant in cycle t drives wrt_en/a3/wrt in cycle t+1, registered from the granted requester's addr/data.
  - A cycle with no grant gives wrt_en=0 at t+1; a3 and wrt hold their previous values.
  - Throughput is one write per cycle.
- x0 filter: a granted request with addr=0 is accepted (ready=1) but produces wrt_en=0 in t+1.
- Handshake rules:
  - Requesters hold valid/addr/data stable until ready.
  - ready never depends on ready of another block, so there are no loops.
- Reset mid-operation: rst in any state, including mid-CLEAR, returns to IDLE on that edge.
  - Outputs go to reset values.
  - A pending registered write is discarded (wrt_en=0 next cycle).
  - A new start is required to re-sweep.
- Simultaneous events:
  - rst has priority over start and all requests.
  - start during CLEAR or RUN has no effect.

Optional Feature:
- Macro: REGFILE_WB_ARBITER_STATS_EN.
- When defined:
  - Adds output port grant_cnt, width NREQ*16: one 16-bit counter per requester at [i*16 +: 16].
  - A counter increments on each completed handshake of its requester, including addr=0.
  - Counters saturate at 16'hFFFF and clear on rst.
- When undefined: the port and the counters do not exist, and behaviour is otherwise identical.

Decomposition:
- Shared package regfile_pkg:
  - State encoding constants ST_IDLE=2'd0, ST_CLEAR=2'd1, ST_RUN=2'd2.
  - Default widths DW, AW, NREG.
- One sub-module: rr_arbiter (NREQ-wide round-robin priority select with pointer update), reusable later for memory-port sharing.
- The FSM, sweep counter and output registers stay in the top module.

Test Plan:
- Init sweep: rst=1 one cycle, start=1 → wrt_en=1 for exactly 31 consecutive cycles with a3=1..31 and wrt=0, then init_done=1. The register file reads back 0 at a1=6.
- Single requester: RUN, req_valid=3'b001, addr=6, data=50 → req_ready=3'b001 same cycle. The next cycle has wrt_en=1, a3=6, wrt=50, and rd1 at a1=6 returns 50.
- Fairness: all three valid continuously with addrs 5/4/9 and data 2/7/9 → grants cycle 0,1,2,0,1,2…. The write stream a3 is 5,4,9,5,… starting one cycle later.
- x0 filter: requester 1 valid with addr=0, data=7 → req_ready[1]=1 and wrt_en=0 the next cycle. Register 0 still reads 0.
- Reset mid-CLEAR: assert rst at sweep cnt=10 → next cycle wrt_en=0, init_done=0, state IDLE. A subsequent start restarts the sweep at a3=1.
- Stats (REGFILE_WB_ARBITER_STATS_EN): 5 handshakes for requester 2 → grant_cnt[2*16 +: 16]=5, other counters 0. After rst all counters read 0.
